// File: rtl/sll_iter.sv
// Iterative logical-left shifter: one power-of-two stage (1,2,4,8,16) per clock.
// Reports unsigned (lost ones) and signed (sign not preserved) overflow of the shift.
module sll_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       sh_amt,
  output logic [WIDTH-1:0] data_out,
  output logic             uovf,
  output logic             sovf,
  output logic             busy,
  output logic             data_ready
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       k_q;
  logic [4:0]       amt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             lost_u_q, lost_u_d;
  logic             lost_s_q, lost_s_d;
  logic [WIDTH-1:0] data_out_q;
  logic             uovf_q, sovf_q;

  logic             accept;
  logic             last_stage;
  int unsigned      stage_sh;
  logic [WIDTH-1:0] top_bits;
  logic [WIDTH-1:0] ones_mask;
  logic             stage_u, stage_s;

  assign accept     = (state_q != StShift) && ctrl_start;
  assign last_stage = (k_q == 3'd4);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ctrl_start) state_d = StShift;
      StShift: if (last_stage) state_d = StDone;
      StDone:  state_d = ctrl_start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; both decode a register so they are glitch-free registered values
  always_comb begin
    busy       = (state_q == StShift);
    data_ready = (state_q == StDone);
  end

  // One shift stage. Signed overflow composes per stage: the whole shift keeps the
  // sign exactly when every stage keeps its top (2^k)+1 bits identical.
  always_comb begin
    stage_sh  = 32'd1 << k_q;
    top_bits  = acc_q >> (WIDTH - 1 - stage_sh);
    ones_mask = {WIDTH{1'b1}} >> (WIDTH - 1 - stage_sh);
    stage_u   = (acc_q >> (WIDTH - stage_sh)) != '0;
    stage_s   = (top_bits != '0) && (top_bits != ones_mask);
    acc_d     = acc_q;
    lost_u_d  = lost_u_q;
    lost_s_d  = lost_s_q;
    if (amt_q[k_q]) begin
      acc_d    = acc_q << stage_sh;
      lost_u_d = lost_u_q | stage_u;
      lost_s_d = lost_s_q | stage_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_q        <= '0;
      amt_q      <= '0;
      acc_q      <= '0;
      lost_u_q   <= 1'b0;
      lost_s_q   <= 1'b0;
      data_out_q <= '0;
      uovf_q     <= 1'b0;
      sovf_q     <= 1'b0;
    end else if (accept) begin
      k_q      <= '0;
      amt_q    <= sh_amt;
      acc_q    <= data_in;
      lost_u_q <= 1'b0;
      lost_s_q <= 1'b0;
    end else if (state_q == StShift) begin
      k_q      <= k_q + 3'd1;
      acc_q    <= acc_d;
      lost_u_q <= lost_u_d;
      lost_s_q <= lost_s_d;
      if (last_stage) begin
        data_out_q <= acc_d;
        uovf_q     <= lost_u_d;
        sovf_q     <= lost_s_d;
      end
    end
  end

  assign data_out = data_out_q;
  assign uovf     = uovf_q;
  assign sovf     = sovf_q;

endmodule

// File: tb/tb_sll_iter.sv
// Bench for sll_iter: directed vectors with literal expectations plus a
// transaction-level model compared against the DUT every cycle.
module tb_sll_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_in;
  logic [4:0]  sh_amt;
  logic [31:0] data_out;
  logic        uovf, sovf, busy, data_ready;

  sll_iter #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_start (ctrl_start),
    .data_in    (data_in),
    .sh_amt     (sh_amt),
    .data_out   (data_out),
    .uovf       (uovf),
    .sovf       (sovf),
    .busy       (busy),
    .data_ready (data_ready)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference rules expressed arithmetically on the whole operand.
  function automatic logic [31:0] ref_out(input logic [31:0] d, input logic [4:0] a);
    return d << a;
  endfunction

  function automatic logic ref_u(input logic [31:0] d, input logic [4:0] a);
    logic [63:0] w;
    w = {32'd0, d} << a;
    return |w[63:32];
  endfunction

  function automatic logic ref_s(input logic [31:0] d, input logic [4:0] a);
    longint x;
    x = longint'($signed(d));
    x = x * (longint'(1) << a);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  // Transaction model: phase 0 idle, 1..5 busy, 6 result cycle.
  int          m_phase = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_din;
  logic [4:0]  m_amt;
  logic [31:0] e_out;
  logic        e_u, e_s;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1;
      m_phase = 0;
      e_out   = '0;
      e_u     = 1'b0;
      e_s     = 1'b0;
    end else if (m_phase == 0 || m_phase == 6) begin
      if (ctrl_start) begin
        m_din   = data_in;
        m_amt   = sh_amt;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == 6) begin
        e_out = ref_out(m_din, m_amt);
        e_u   = ref_u(m_din, m_amt);
        e_s   = ref_s(m_din, m_amt);
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("m_busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 5));
      chk("m_ready", 32'(data_ready), 32'(m_phase == 6));
      chk("m_out", data_out, e_out);
      chk("m_uovf", 32'(uovf), 32'(e_u));
      chk("m_sovf", 32'(sovf), 32'(e_s));
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after the result.
  task automatic run_op(input logic [31:0] din, input logic [4:0] amt, input logic [31:0] eo,
                        input logic eu, input logic es, input string tag);
    int cyc;
    ctrl_start = 1'b1;
    data_in    = din;
    sh_amt     = amt;
    @(negedge clock);
    ctrl_start = 1'b0;
    cyc = 1;
    while (!data_ready && cyc < 20) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd6);
    chk({tag, "_out"}, data_out, eo);
    chk({tag, "_uovf"}, 32'(uovf), 32'(eu));
    chk({tag, "_sovf"}, 32'(sovf), 32'(es));
    @(negedge clock);
    chk({tag, "_pulse"}, 32'(data_ready), 32'd0);
  endtask

  initial begin
    int ops;
    int cyc;
    reset      = 1'b1;
    ctrl_start = 1'b0;
    data_in    = '0;
    sh_amt     = '0;
    repeat (2) @(negedge clock);
    chk("rst_out", data_out, 32'd0);
    chk("rst_flags", {29'd0, uovf, sovf, busy}, 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Model pins against hand-computed values
    chk("ref_s_1_31", 32'(ref_s(32'h1, 5'd31)), 32'd1);
    chk("ref_u_fff0_4", 32'(ref_u(32'hFFFF_FFF0, 5'd4)), 32'd1);
    chk("ref_s_fff0_4", 32'(ref_s(32'hFFFF_FFF0, 5'd4)), 32'd0);

    run_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b1, "t1");
    run_op(32'hFFFF_FFF0, 5'd4, 32'hFFFF_FF00, 1'b1, 1'b0, "t2a");
    run_op(32'h4000_0000, 5'd1, 32'h8000_0000, 1'b0, 1'b1, "t2b");
    run_op(32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 1'b0, "t3");
    run_op(32'hC000_0000, 5'd1, 32'h8000_0000, 1'b1, 1'b0, "t3b");

    // Start while busy is ignored; start in the result cycle is accepted
    ctrl_start = 1'b1; data_in = 32'h0000_00FF; sh_amt = 5'd8;
    @(negedge clock); ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock); ctrl_start = 1'b1; data_in = 32'h1; sh_amt = 5'd1;
    @(negedge clock); ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t4_ready_a", 32'(data_ready), 32'd1);
    chk("t4_out_a", data_out, 32'h0000_FF00);
    ctrl_start = 1'b1; data_in = 32'h1; sh_amt = 5'd1;
    for (int c = 7; c <= 11; c++) begin
      @(negedge clock);
      ctrl_start = 1'b0;
      chk("t4_hold", data_out, 32'h0000_FF00);
      chk("t4_busy", 32'(busy), 32'd1);
    end
    @(negedge clock);
    chk("t4_ready_b", 32'(data_ready), 32'd1);
    chk("t4_out_b", data_out, 32'h0000_0002);
    @(negedge clock);

    // Reset mid-operation aborts with no later pulse
    ctrl_start = 1'b1; data_in = 32'h1234_5678; sh_amt = 5'd5;
    @(negedge clock); ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("t5_out", data_out, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_flags", {30'd0, uovf, sovf}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("t5_noready", 32'(data_ready), 32'd0);
    end

    // Reset and start on the same edge: start dropped
    reset = 1'b1; ctrl_start = 1'b1; data_in = 32'h5; sh_amt = 5'd3;
    @(negedge clock); reset = 1'b0; ctrl_start = 1'b0;
    chk("rs_busy", 32'(busy), 32'd0);
    @(negedge clock);
    chk("rs_busy2", 32'(busy), 32'd0);

    // Random sweep with start held high: new pairs every cycle, most ignored
    ops = 0;
    cyc = 0;
    ctrl_start = 1'b1;
    while (ops < 10000 && cyc < 70000) begin
      data_in = $urandom;
      sh_amt  = 5'($urandom_range(0, 31));
      @(negedge clock);
      cyc++;
      if (data_ready) ops++;
    end
    chk("sweep_ops", 32'(ops), 32'd10000);
    ctrl_start = 1'b0;
    repeat (8) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sll_iter.md
# sll_iter

Iterative logical-left shifter for the multdiv unit, the left-direction companion to the combinational arithmetic right shifter. It applies the five power-of-two shift stages (1, 2, 4, 8, 16) one per clock under a start/ready handshake. It reports unsigned and signed overflow of the shift so the multiplier and divider datapaths can use it without an extra checker.

## Interface

- `WIDTH`, default 32: operand width.
  - Must be greater than 16. Five stages cover shift amounts 0–31.
- `clock` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `ctrl_start` input, 1 bit: request a shift. Sampled only when `busy` = 0.
- `data_in` input, `WIDTH` bits: operand. Captured on an accepted start.
- `sh_amt` input, 5 bits: shift amount. Captured on an accepted start.
- `data_out` output, `WIDTH` bits: `data_in << sh_amt`, zero-filled.
- `uovf` output, 1 bit: at least one 1 bit was shifted out.
- `sovf` output, 1 bit: the result is not equal to `data_in` × 2^`sh_amt` as a signed number.
- `busy` output, 1 bit: a shift is in progress. New starts are ignored while it is high.
- `data_ready` output, 1 bit: one-cycle pulse when `data_out`, `uovf` and `sovf` are updated.

## Operation

- **States:** IDLE, SHIFT, DONE. A 3-bit stage counter `k` runs 0..4.
- **IDLE or DONE with `ctrl_start` = 1:**
  - Capture `data_in` into the accumulator and `sh_amt` into the amount register.
  - Clear the lost-bit flags and set `k` = 0.
  - Go to SHIFT.
- **IDLE with `ctrl_start` = 0:** stay in IDLE.
- **DONE with `ctrl_start` = 0:** go to IDLE.
- **SHIFT, on each edge:**
  - If `amt[k]` = 1, shift the accumulator left by 2^k and fill with zeros. Otherwise hold it.
  - OR the discarded top 2^k bits into the lost-bit flag for `uovf`.
  - Increment `k`. When `k` = 4 has been applied, go to DONE.
- **Entering DONE:**
  - Load `data_out` from the accumulator and load `uovf` and `sovf`.
  - Assert `data_ready` for the DONE cycle only.
- **`uovf` rule:** 1 if and only if `data_in[WIDTH-1 : WIDTH-sh_amt]` contains a 1. For `sh_amt` = 0, `uovf` = 0.
- **`sovf` rule:** 1 if and only if the bits `data_in[WIDTH-1 : WIDTH-1-sh_amt]` are not all identical. For `sh_amt` = 0, `sovf` = 0.
  - Computing it per stage is permitted. The outputs must match this rule exactly.
- **Output holding:** `data_out`, `uovf` and `sovf` change only on entry to DONE (or on reset). They hold the previous result during SHIFT.
- **`ctrl_start` while `busy` = 1:** ignored completely. It is not queued and has no effect on the running operation.
- **`sh_amt` = 0:** the operation still takes the full latency. `data_out` = `data_in` and both flags are 0.

## Timing

- **Latency:** `ctrl_start` is accepted at edge 0 (cycle 0).
  - `busy` = 1 in cycles 1–5, one stage per edge (edges 1–5).
  - `data_ready` = 1 and the results are valid in cycle 6.
  - Latency is fixed at 6 cycles and does not depend on `sh_amt`.
- **Throughput:** a start asserted in the DONE cycle (cycle 6) is accepted. Back-to-back results are therefore 6 cycles apart.
- **`busy`:** a registered output, 1 only in SHIFT.
- **`data_ready`:** a registered output, 1 only in DONE.
- **Reset value of every output:** `data_out` = 0, `uovf` = 0, `sovf` = 0, `busy` = 0, `data_ready` = 0. The state is IDLE and `k` = 0.
- **Reset mid-operation:** the operation is aborted.
  - In the cycle after the reset edge, all outputs hold their reset values.
  - No `data_ready` pulse is produced for the aborted operation.
- **Reset and `ctrl_start` on the same edge:** reset wins and the start is dropped.

## Test plan

1. `data_in` = 0x0000_0001, `sh_amt` = 31, start in cycle 0 -> cycle 6: `data_out` = 0x8000_0000, `uovf` = 0, `sovf` = 1, `data_ready` = 1 for exactly one cycle, `busy` = 1 in cycles 1–5.
2. `data_in` = 0xFFFF_FFF0, `sh_amt` = 4 -> `data_out` = 0xFFFF_FF00, `uovf` = 1, `sovf` = 0. Then `data_in` = 0x4000_0000, `sh_amt` = 1 -> `data_out` = 0x8000_0000, `uovf` = 0, `sovf` = 1.
3. `data_in` = 0x8000_0000, `sh_amt` = 0 -> cycle 6: `data_out` = 0x8000_0000, `uovf` = 0, `sovf` = 0.
4. Start A (0x0000_00FF, `sh_amt` = 8) in cycle 0. Assert `ctrl_start` again in cycle 3 with 0x1 / 1 -> the cycle-3 start is ignored; cycle 6 gives 0x0000_FF00.
   - Then start B (0x1, `sh_amt` = 1) in cycle 6 -> B is accepted and gives `data_out` = 0x2 with `data_ready` in cycle 12.
   - `data_out` holds 0x0000_FF00 during cycles 7–11.
5. Start 0x1234_5678 with `sh_amt` = 5, assert `reset` in cycle 3 -> from cycle 4: all outputs 0, `busy` = 0. No `data_ready` pulse appears in any later cycle until a new start.
6. Random sweep: 10k random (`data_in`, `sh_amt`) pairs -> `data_out`, `uovf` and `sovf` match a reference model built from the rules above on every `data_ready`, with latency always 6.
